sw_array_ctrl: RTL

Sequencer for a linear Smith-Waterman systolic array of NUM_PE processing elements with affine gap scoring.
- Loads the query into the array through the S/store_S shift chain.
- Streams reference bases in through the T/init chain, inserting global stalls when either input stream starves.
- Drains the pipeline after the last base.
- Converts the array's per-PE high-score flags into (PE index, reference position) hit reports.
- Sits between the host-side query/reference streams and PE 0 of the array.

---
 rtl/sw_ctrl_pkg.sv | 18 +
 rtl/sw_hit_encoder.sv | 29 ++
 rtl/sw_array_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sw_ctrl_pkg.sv
// Shared definitions for the Smith-Waterman array sequencer.
//   state_e   : sequencer FSM states (IDLE, LOAD, RUN, DRAIN)
//   BASE_*    : 2-bit nucleotide encoding used on the query/reference streams
package sw_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

endpackage

// File: rtl/sw_hit_encoder.sv
// Combinational hit encoder over the per-PE high-score flags.
//   vec_i   : per-PE flags, bit i from PE i
//   idx_o   : index of the lowest set bit (0 when no bit is set)
//   multi_o : more than one flag set
//   pop_o   : number of flags set
module sw_hit_encoder #(
  parameter int NUM_PE   = 64,
  parameter int PE_IDX_W = 6,
  parameter int CNT_W    = $clog2(NUM_PE + 1)
) (
  input  logic [NUM_PE-1:0]   vec_i,
  output logic [PE_IDX_W-1:0] idx_o,
  output logic                multi_o,
  output logic [CNT_W-1:0]    pop_o
);

  // Scanning from the top down lets the lowest set bit overwrite last.
  always_comb begin
    idx_o = '0;
    pop_o = '0;
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = PE_IDX_W'(i);
      pop_o = pop_o + CNT_W'(vec_i[i]);
    end
  end

  assign multi_o = (pop_o > CNT_W'(1));

endmodule

// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear Smith-Waterman systolic array (affine gap scoring).
// Loads the query through the S/store_S chain, streams the reference through
// the T/init chain with global stalls when a stream starves, drains the
// pipeline for NUM_PE cycles and turns per-PE high-score flags into hit
// reports (PE index, reference position).
//
// Ports: clk/rst (sync, active-high); start/cfg_threshold job control;
//   q_* query stream, r_* reference stream (host side);
//   arr_* registered drive to PE 0; high_score_vec flags from the array;
//   hit_* one-cycle hit reports; busy/done job status; dbg_state FSM state.
//
// Handshake: a base transfers on a cycle where valid and ready are both high;
// ready depends only on the FSM state, never on valid, and valid may be
// dropped at any time (the array is stalled for that cycle).
//
// Optional: define SW_ARRAY_CTRL_HIT_COUNT_EN to add output hit_count, a
// saturating sum of flagged PEs over all report cycles of the job.
module sw_array_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int NUM_PE     = 64,
  parameter int WIDTH      = 10,
  parameter int POS_W      = 32,
  parameter int PE_IDX_W   = 6,
  parameter int INIT_V_VAL = 0,
  parameter int INIT_E_VAL = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    cfg_threshold,
  input  logic [1:0]          q_data,
  input  logic                q_valid,
  output logic                q_ready,
  input  logic [1:0]          r_data,
  input  logic                r_valid,
  input  logic                r_last,
  output logic                r_ready,
  output logic                arr_stall,
  output logic [1:0]          arr_S_in,
  output logic                arr_store_S_in,
  output logic [1:0]          arr_T_in,
  output logic                arr_init_in,
  output logic [WIDTH-1:0]    arr_init_V,
  output logic [WIDTH-1:0]    arr_init_E,
  output logic [WIDTH-1:0]    arr_threshold,
  input  logic [NUM_PE-1:0]   high_score_vec,
  output logic                hit_valid,
  output logic [PE_IDX_W-1:0] hit_pe,
  output logic [POS_W-1:0]    hit_pos,
  output logic                hit_multi,
`ifdef SW_ARRAY_CTRL_HIT_COUNT_EN
  output logic [POS_W-1:0]    hit_count,
`endif
  output logic                busy,
  output logic                done,
  output state_e              dbg_state
);

  localparam int                 CNT_W    = $clog2(NUM_PE + 1);
  localparam logic [PE_IDX_W-1:0] LAST_IDX = PE_IDX_W'(NUM_PE - 1);

  state_e              state_q;
  logic [PE_IDX_W-1:0] load_cnt_q, drain_cnt_q;
  logic [POS_W-1:0]    ref_cnt_q, adv_cnt_q;
  logic                adv_q;
  logic                stall_q, store_q, init_q, done_q;
  logic [1:0]          s_q, t_q;
  logic [WIDTH-1:0]    thr_q;
  logic                hit_valid_q, hit_multi_q;
  logic [PE_IDX_W-1:0] hit_pe_q;
  logic [POS_W-1:0]    hit_pos_q;

  logic [PE_IDX_W-1:0] enc_idx;
  logic                enc_multi;
  logic [CNT_W-1:0]    enc_pop;
  logic                adv, report;

  sw_hit_encoder #(
    .NUM_PE  (NUM_PE),
    .PE_IDX_W(PE_IDX_W),
    .CNT_W   (CNT_W)
  ) u_enc (
    .vec_i  (high_score_vec),
    .idx_o  (enc_idx),
    .multi_o(enc_multi),
    .pop_o  (enc_pop)
  );

  // adv marks a cycle whose decision lets the array step (its registered
  // arr_stall will be 0 in RUN/DRAIN). Flags appear the cycle after such a
  // step, so only adv_q cycles may report; frozen cycles cannot re-report.
  assign adv    = (state_q == RUN && r_valid) || (state_q == DRAIN);
  assign report = adv_q && (enc_pop != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      ref_cnt_q   <= '0;
      adv_cnt_q   <= '0;
      adv_q       <= 1'b0;
      stall_q     <= 1'b0;
      store_q     <= 1'b0;
      init_q      <= 1'b0;
      s_q         <= '0;
      t_q         <= '0;
      thr_q       <= '0;
      done_q      <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_pe_q    <= '0;
      hit_pos_q   <= '0;
      hit_multi_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      adv_q       <= adv;
      hit_valid_q <= report;
      if (adv) adv_cnt_q <= adv_cnt_q + POS_W'(1);
      if (report) begin
        hit_pe_q    <= enc_idx;
        // The flagging PE saw the base that entered (hit_pe) steps earlier.
        hit_pos_q   <= adv_cnt_q - POS_W'(1) - POS_W'(enc_idx);
        hit_multi_q <= enc_multi;
      end
      case (state_q)
        IDLE: begin
          stall_q <= 1'b0;
          store_q <= 1'b0;
          init_q  <= 1'b0;
          if (start) begin
            thr_q      <= cfg_threshold;
            load_cnt_q <= '0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (q_valid) begin
            s_q        <= q_data;
            store_q    <= 1'b1;
            stall_q    <= 1'b0;
            load_cnt_q <= load_cnt_q + PE_IDX_W'(1);
            if (load_cnt_q == LAST_IDX) begin
              state_q   <= RUN;
              adv_cnt_q <= '0;
              ref_cnt_q <= '0;
            end
          end else begin
            stall_q <= 1'b1;
            store_q <= 1'b0;
          end
        end
        RUN: begin
          store_q <= 1'b0;
          if (r_valid) begin
            t_q       <= r_data;
            init_q    <= 1'b1;
            stall_q   <= 1'b0;
            ref_cnt_q <= ref_cnt_q + POS_W'(1);
            if (r_last) begin
              state_q     <= DRAIN;
              drain_cnt_q <= '0;
            end
          end else begin
            stall_q <= 1'b1;
            init_q  <= 1'b0;
          end
        end
        DRAIN: begin
          t_q         <= '0;
          init_q      <= 1'b0;
          stall_q     <= 1'b0;
          drain_cnt_q <= drain_cnt_q + PE_IDX_W'(1);
          if (drain_cnt_q == LAST_IDX) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SW_ARRAY_CTRL_HIT_COUNT_EN
  logic [POS_W-1:0] hit_count_q;
  logic [POS_W:0]   hc_sum;

  assign hc_sum = {1'b0, hit_count_q} + (POS_W + 1)'(enc_pop);

  // A start in IDLE clears the count even if a late report lands that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q <= '0;
    end else if (state_q == IDLE && start) begin
      hit_count_q <= '0;
    end else if (report) begin
      hit_count_q <= hc_sum[POS_W] ? '1 : hc_sum[POS_W-1:0];
    end
  end

  assign hit_count = hit_count_q;
`endif

  assign q_ready        = (state_q == LOAD);
  assign r_ready        = (state_q == RUN);
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign dbg_state      = state_q;
  assign arr_stall      = stall_q;
  assign arr_S_in       = s_q;
  assign arr_store_S_in = store_q;
  assign arr_T_in       = t_q;
  assign arr_init_in    = init_q;
  assign arr_init_V     = WIDTH'(INIT_V_VAL);
  assign arr_init_E     = WIDTH'(INIT_E_VAL);
  assign arr_threshold  = thr_q;
  assign hit_valid      = hit_valid_q;
  assign hit_pe         = hit_pe_q;
  assign hit_pos        = hit_pos_q;
  assign hit_multi      = hit_multi_q;

endmodule
